// File: rtl/ceps_frame_packer_if.sv
// Output stream of the cepstral frame packer: one coefficient per beat with
// first/last markers and the frame sequence number.
interface ceps_frame_packer_if #(
  parameter int CEPS_WIDTH     = 16,
  parameter int FRAME_ID_WIDTH = 16
);
  logic                      valid;
  logic                      ready;
  logic [CEPS_WIDTH-1:0]     data;
  logic                      first;
  logic                      last;
  logic [FRAME_ID_WIDTH-1:0] frame_id;

  // Packer side drives the beat, consumer side drives ready.
  modport master (output valid, data, first, last, frame_id, input ready);
  modport slave  (input valid, data, first, last, frame_id, output ready);
endinterface

// File: rtl/ceps_frame_packer.sv
// Cepstral frame packer: gathers NUM_CEPS coefficients per frame from the DCT
// (random-order pointer writes closed by a done pulse) into a two-bank
// ping-pong buffer and streams complete frames out in commit order.
// Frames that find no free bank, or close with missing coefficients, are
// dropped and counted.
module ceps_frame_packer #(
  parameter int NUM_CEPS       = 12,
  parameter int CEPS_WIDTH     = 16,
  parameter int FRAME_ID_WIDTH = 16,
  localparam int PTR_W         = (NUM_CEPS > 1) ? $clog2(NUM_CEPS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dct_valid_i,
  input  logic [PTR_W-1:0]          ceps_ptr_i,
  input  logic [CEPS_WIDTH-1:0]     ceps_i,
  input  logic                      dct_done_i,
  ceps_frame_packer_if.master       m,
  output logic                      overflow_o,
  output logic                      incomplete_o,
  output logic [FRAME_ID_WIDTH-1:0] drop_count_o
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_CEPS - 1);

  // Coefficient storage, two banks.
  logic [CEPS_WIDTH-1:0]     bank_q    [2][NUM_CEPS];

  // Buffer bookkeeping.
  logic [1:0]                full_q, full_d;
  logic [FRAME_ID_WIDTH-1:0] bank_id_q [2];
  logic [FRAME_ID_WIDTH-1:0] bank_id_d [2];
  logic                      wr_bank_q, wr_bank_d;
  logic                      rd_bank_q, rd_bank_d;
  logic [PTR_W-1:0]          rd_idx_q, rd_idx_d;

  // Per-frame write tracking.
  logic [NUM_CEPS-1:0]       mask_q, mask_d;
  logic                      drop_q, drop_d;
  logic [FRAME_ID_WIDTH-1:0] frame_id_q, frame_id_d;

  // Status.
  logic                      overflow_q, overflow_d;
  logic                      incomplete_q, incomplete_d;
  logic [FRAME_ID_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  // Decoded events for this cycle.
  logic                      ptr_ok;
  logic                      frame_start;
  logic                      drop_eff;
  logic                      wr_en;
  logic                      xfer;
  logic [NUM_CEPS-1:0]       mask_upd;
  logic [FRAME_ID_WIDTH-1:0] drop_cnt_inc;

  assign ptr_ok       = int'(ceps_ptr_i) < NUM_CEPS;
  // The keep/drop decision is taken once, on the first write of a frame; a
  // bank freed later in the same frame does not rescue it.
  assign frame_start  = dct_valid_i && (mask_q == '0) && !drop_q;
  assign drop_eff     = drop_q || (frame_start && full_q[wr_bank_q]);
  assign wr_en        = dct_valid_i && ptr_ok && !drop_eff;
  assign xfer         = m.valid && m.ready;
  assign drop_cnt_inc = (&drop_cnt_q) ? drop_cnt_q : drop_cnt_q + 1'b1;

  // Next-state for bookkeeping: read-side advance, write tracking, frame close.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    full_d       = full_q;
    bank_id_d    = bank_id_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    rd_idx_d     = rd_idx_q;
    drop_d       = drop_eff;
    frame_id_d   = frame_id_q;
    overflow_d   = overflow_q;
    incomplete_d = incomplete_q;
    drop_cnt_d   = drop_cnt_q;
    mask_upd     = mask_q;

    if (wr_en) begin
      mask_upd[ceps_ptr_i] = 1'b1;
    end
    mask_d = mask_upd;

    if (xfer) begin
      if (rd_idx_q == LAST_IDX) begin
        rd_idx_d          = '0;
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end

    // The write bank was empty when this frame started and only a commit can
    // fill it, so it is never the bank being drained above.
    if (dct_done_i) begin
      if (drop_eff) begin
        overflow_d = 1'b1;
        drop_cnt_d = drop_cnt_inc;
      end else if (&mask_upd) begin
        full_d[wr_bank_q]    = 1'b1;
        bank_id_d[wr_bank_q] = frame_id_q;
        wr_bank_d            = ~wr_bank_q;
      end else begin
        incomplete_d = 1'b1;
        drop_cnt_d   = drop_cnt_inc;
      end
      drop_d     = 1'b0;
      mask_d     = '0;
      frame_id_d = frame_id_q + 1'b1;
    end
  end

  // Coefficient write into the current write bank.
  // NOTE: storage has no reset; the full flags alone decide whether a bank's
  // contents mean anything, so stale data is never exposed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank_q[wr_bank_q][ceps_ptr_i] <= ceps_i;
    end
  end

  // Bookkeeping and status registers with synchronous reset.
  // NOTE: <= throughout, so every flop samples the pre-edge value of the rest.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q       <= '0;
      bank_id_q[0] <= '0;
      bank_id_q[1] <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      rd_idx_q     <= '0;
      mask_q       <= '0;
      drop_q       <= 1'b0;
      frame_id_q   <= '0;
      overflow_q   <= 1'b0;
      incomplete_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      full_q       <= full_d;
      bank_id_q[0] <= bank_id_d[0];
      bank_id_q[1] <= bank_id_d[1];
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      rd_idx_q     <= rd_idx_d;
      mask_q       <= mask_d;
      drop_q       <= drop_d;
      frame_id_q   <= frame_id_d;
      overflow_q   <= overflow_d;
      incomplete_q <= incomplete_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Output beat is a pure function of registered state, never of ready.
  // Data is forced to zero while idle so nothing unwritten leaks out.
  assign m.valid      = full_q[rd_bank_q];
  assign m.data       = m.valid ? bank_q[rd_bank_q][rd_idx_q] : '0;
  assign m.first      = m.valid && (rd_idx_q == '0);
  assign m.last       = m.valid && (rd_idx_q == LAST_IDX);
  assign m.frame_id   = bank_id_q[rd_bank_q];

  assign overflow_o   = overflow_q;
  assign incomplete_o = incomplete_q;
  assign drop_count_o = drop_cnt_q;

endmodule

// File: doc/ceps_frame_packer.md
Name: ceps_frame_packer

Overview:
- Sits directly downstream of the DCT stage in the MFCC pipeline.
- Collects the NUM_CEPS cepstral coefficients of each frame, which arrive as pointer/sample writes followed by a done pulse.
- Holds up to two complete frames in a ping-pong buffer.
- Streams each frame out over a valid/ready interface with first/last markers and a frame ID, counting frames dropped on overflow or arriving incomplete.

Parameters:
NUM_CEPS, 12, coefficients per frame
CEPS_WIDTH, 16, bits per coefficient
FRAME_ID_WIDTH, 16, width of frame sequence counter and drop counters

Ports:
clk  input  1  clock; the block uses this single clock domain
rst  input  1  reset, synchronous, active-high
dct_valid_i  input  1  coefficient write strobe from DCT
ceps_ptr_i  input  $clog2(NUM_CEPS)  coefficient index for the write
ceps_i  input  CEPS_WIDTH  coefficient value
dct_done_i  input  1  one-cycle pulse, end of current frame
m_valid_o  output  1  output word valid
m_ready_i  input  1  downstream ready
m_data_o  output  CEPS_WIDTH  coefficient, index order 0..NUM_CEPS-1
m_first_o  output  1  high on coefficient 0 of a frame
m_last_o  output  1  high on coefficient NUM_CEPS-1
m_frame_id_o  output  FRAME_ID_WIDTH  sequence number of the frame being output
overflow_o  output  1  sticky; set when a frame is dropped for lack of buffer space
incomplete_o  output  1  sticky; set when dct_done_i arrives with missing coefficients
drop_count_o  output  FRAME_ID_WIDTH  frames dropped (overflow plus incomplete), saturating

Behaviour:
- Reset, on a synchronous rst=1:
  - All outputs 0.
  - Both banks EMPTY; wr_bank=rd_bank=0; rd_idx=0; written-mask=0; drop flag=0; frame_id counter=0.
  - Reset mid-frame or mid-stream discards all buffered data. m_valid_o is low the cycle after rst.
- Storage: two banks of NUM_CEPS x CEPS_WIDTH registers. Each bank carries a full flag and a stored frame ID.
- Write side:
  - Write accepted when dct_valid_i=1, ceps_ptr_i<NUM_CEPS and the frame's drop flag=0.
  - The write sets mask[ceps_ptr_i]. A repeated pointer overwrites; last value wins.
  - ceps_ptr_i>=NUM_CEPS is ignored.
- Drop decision is made once per frame:
  - It is taken at the first dct_valid_i of a frame (mask==0 and drop flag==0).
  - If full[wr_bank]=1 in that cycle, the drop flag is set and every write until dct_done_i is discarded.
  - A bank freed later in the same frame does not un-drop it.
- On dct_done_i:
  - A dct_valid_i in the same cycle is applied first.
  - If the drop flag is set: overflow_o<=1, drop_count++ (saturates at all-ones), drop flag cleared.
  - Else if mask is all ones: full[wr_bank]<=1, bank ID<=frame_id, wr_bank toggles.
  - Else (including a done with no writes): incomplete_o<=1, drop_count++. The bank stays empty and its contents are don't-care.
  - In every case: mask<=0 and frame_id<=frame_id+1, wrapping. Dropped frames therefore appear as ID gaps downstream.
- Read side:
  - m_valid_o=full[rd_bank].
  - m_data_o=bank[rd_bank][rd_idx].
  - m_first_o=(rd_idx==0)&m_valid_o; m_last_o=(rd_idx==NUM_CEPS-1)&m_valid_o.
  - m_frame_id_o is the ID of rd_bank.
- Transfer occurs when m_valid_o & m_ready_i:
  - rd_idx++.
  - At the last index: rd_idx<=0, full[rd_bank]<=0, rd_bank toggles.
- AXI-stream rules:
  - Once m_valid_o rises, it and m_data_o, m_first_o, m_last_o and m_frame_id_o stay stable until the transfer.
  - m_valid_o does not depend combinationally on m_ready_i.
- Latency: a frame committed by dct_done_i in cycle N, into an empty rd_bank, gives m_valid_o=1 in cycle N+1. Best-case throughput is one word per cycle.
- Simultaneous events:
  - A commit into one bank and the final read of the other bank in the same cycle both take effect.
  - A freed bank becomes writable the next cycle.
  - A frame ordered while both banks are full is dropped.
- Ordering: frames are output strictly in commit order. rd_bank always points to the oldest full bank.
- Clearing: overflow_o and incomplete_o clear only on rst.

Test Plan:
- Single frame: after reset, write ptr 0..11 with values 0x0100+ptr, then dct_done_i, with m_ready_i=1 -> m_valid_o rises 1 cycle after done, 12 consecutive words 0x0100..0x010B, m_first_o on word 0, m_last_o on word 11, m_frame_id_o=0.
- Out-of-order and duplicate writes: ptr order 11..0, then ptr 3 rewritten with 0xBEEF before done -> output index order 0..11 with word 3 = 0xBEEF; incomplete_o stays 0.
- Backpressure and overflow: hold m_ready_i=0 and send frames 0, 1, 2 -> frames 0 and 1 buffered, frame 2 dropped, overflow_o=1, drop_count_o=1. Release ready -> IDs 0 then 1 output intact. Frame 3 is then accepted with ID 3.
- Incomplete frame: write ptr 0..10 only, then done -> incomplete_o=1, drop_count_o=1, no output. The next full frame outputs with ID 1.
- Concurrency: dct_done_i commit into bank 1 in the same cycle as the m_last_o transfer of bank 0 -> no bubble beyond 1 cycle; bank 1 frame follows correctly.
- Reset mid-stream: assert rst after word 5 of a frame with a second frame buffered -> next cycle m_valid_o=0, drop_count_o=0, flags 0; a new frame afterwards outputs with ID 0.
